sd_spi_block_wr: RTL and testbench
==================================

# sd_spi_block_wr

SPI-mode SD card single-block writer: accepts a start pulse and 32-bit sector address from a data source, issues CMD24, streams one 512-byte block (256 × 16-bit words pulled from the source by a request pulse) and handles the card's data response and busy phase. It sits between the card pins and the write interface used by the test-data generator (wr_start_en / wr_sec_addr / wr_req / wr_data / wr_busy). MOSI changes on clk rising edges. MISO is sampled on clk rising edges. The top level drives the card SCK as the inverted clk, so the card samples mid-bit.

## Interface
- TIMEOUT, 16'd1000: maximum clk cycles to wait for the R1 start bit or the data-response start bit.
- BUSY_TIMEOUT, 24'd2_000_000: maximum clk cycles to wait for the card busy to end.
- clk  in  1  system clock; one SPI bit per cycle.
- rst_n  in  1  reset; asynchronous, active-low.
- sd_init_done  in  1  card initialised; start requests are ignored while low.
- wr_start_en  in  1  one-cycle start pulse.
- wr_sec_addr  in  32  sector address, sampled with wr_start_en.
- wr_data  in  16  next word from the source. It is valid from the 2nd cycle after a wr_req pulse.
- wr_req  out  1  one-cycle pulse per word; exactly 256 per accepted write.
- wr_busy  out  1  high while a write is in progress.
- wr_err  out  1  one-cycle pulse on R1 error, rejected data, or timeout.
- sd_miso  in  1  card data out.
- sd_cs  out  1  card chip select, active-low.
- sd_mosi  out  1  card data in.

## Operation
- Reset values: sd_cs=1, sd_mosi=1, wr_busy=0, wr_req=0, wr_err=0, FSM=IDLE.
- IDLE: a start is accepted when wr_start_en=1, sd_init_done=1 and wr_busy=0.
  - The address is latched and wr_busy=1 from the next cycle.
  - Go to CMD.
  - wr_start_en while busy or before init is ignored (no latch, no effect).
- CMD: sd_cs=0. Send 48 bits MSB-first: 0x58, addr[31:24..7:0], 0xFF.
- WAIT_R1: sd_mosi=1.
  - On the first MISO=0, capture 8 bits (including that bit) as R1.
  - R1=0x00 → GAP. Otherwise → error path.
  - No start bit within TIMEOUT cycles → error path.
- GAP: 8 cycles, sd_mosi=1.
- TOKEN: 8 bits, 0xFE.
- DATA: 256 words × 16 bits, MSB-first.
  - wr_req for word 0 pulses in the cycle that drives TOKEN bit 7.
  - wr_req for word k (1..255) pulses in the cycle that drives bit 15 of word k-1.
  - Word k is loaded from wr_data at the edge that begins its bit 15.
- CRC: 16 bits of 1 (CRC is off in SPI mode).
- WAIT_RESP: on the first MISO=0, capture 5 bits 0,s2,s1,s0,1.
  - s=3'b010 → BUSY.
  - Any other s → error flag set, then → BUSY.
  - No start bit within TIMEOUT cycles → error path.
- BUSY: sd_mosi=1; wait until MISO samples 1.
  - Exceeding BUSY_TIMEOUT → error path.
- TAIL: sd_cs=1, sd_mosi=1 for 8 cycles.
  - In the last cycle, wr_busy falls, wr_err pulses if the error flag is set, and the FSM goes to IDLE.
- Error path: set the error flag, go directly to TAIL. No further wr_req pulses are issued for that write.
- Bit and word counters wrap to 0 at the end of each state; the word counter is 8 bits.
- Reset mid-operation takes effect immediately:
  - all outputs return to reset values, sd_cs=1;
  - the in-progress write is abandoned and no wr_err is produced.

## Timing
- Start pulse to sd_cs low: 1 cycle.
- Start pulse to first CMD bit on MOSI: 1 cycle.
- Nominal frame length, with R1 arriving r cycles after CMD, response p cycles after CRC, and busy b cycles:
  - 1 + 48 + r + 8 + 8 + 8 + 4096 + 16 + p + 5 + b + 8 cycles.
- wr_req spacing: 16 cycles between words; 8 cycles from TOKEN start to word 0 MSB.
- wr_err is coincident with the falling edge of wr_busy.
- A new start is accepted in the cycle after wr_busy falls.

## Test plan
- Reset: hold rst_n=0 → sd_cs=1, sd_mosi=1, wr_busy=0, wr_req=0, wr_err=0.
- Normal write, addr 20000, card model: R1=0x00 after 16 cycles, response 0x05, busy 100 cycles, incrementing-word source (wr_data = count-1):
  - MOSI frame begins 58 00 00 4E 20 FF;
  - exactly 256 wr_req pulses;
  - captured block = 0x0000..0x00FF;
  - then 16 ones;
  - wr_busy falls, wr_err=0.
- R1=0x04 → zero wr_req pulses; sd_cs high for 8 cycles; wr_err pulse with wr_busy fall.
- Data response 0x0B (s=101) → all 256 words sent; wr_err pulse after busy and TAIL.
- MISO held high after CMD → wr_err after TIMEOUT+8 cycles; card model sees sd_cs rise.
- wr_start_en before sd_init_done, and again mid-DATA → ignored. Assert rst_n=0 at word 100 → sd_cs=1 immediately, no wr_err; a following start completes normally.

Source files
------------

// File: rtl/sd_spi_block_wr.sv
// SPI-mode SD card single-block writer: CMD24, one 512-byte data packet, data response and busy wait.
// All card-side and source-side outputs are registered on clk rising edges; MISO is sampled on rising edges.
module sd_spi_block_wr #(
    parameter logic [15:0] TIMEOUT      = 16'd1000,
    parameter logic [23:0] BUSY_TIMEOUT = 24'd2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        wr_start_en,
    input  logic [31:0] wr_sec_addr,
    input  logic [15:0] wr_data,
    output logic        wr_req,
    output logic        wr_busy,
    output logic        wr_err,
    input  logic        sd_miso,
    output logic        sd_cs,
    output logic        sd_mosi,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CMD       = 4'd1,
        WAIT_R1   = 4'd2,
        GAP       = 4'd3,
        TOKEN     = 4'd4,
        DATA      = 4'd5,
        CRC       = 4'd6,
        WAIT_RESP = 4'd7,
        BUSY      = 4'd8,
        TAIL      = 4'd9
    } state_t;

    state_t      state;
    logic [47:0] tx_sr;
    logic [47:0] cmd_frame;
    logic [6:0]  rx_sr;
    logic [5:0]  bit_cnt;
    logic [7:0]  word_cnt;
    logic [23:0] wait_cnt;
    logic        got_start;
    logic        err_flag;

    assign cmd_frame = {8'h58, wr_sec_addr, 8'hFF};
    assign dbg_state = state;

    // Source handshake: wr_start_en is a one-cycle request taken only in IDLE with sd_init_done high
    // and wr_busy low; each wr_req pulse asks for one word, which must sit on wr_data from the 2nd cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sd_cs     <= 1'b1;
            sd_mosi   <= 1'b1;
            wr_busy   <= 1'b0;
            wr_req    <= 1'b0;
            wr_err    <= 1'b0;
            tx_sr     <= '1;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            wait_cnt  <= '0;
            got_start <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            wr_req <= 1'b0;
            wr_err <= 1'b0;
            case (state)
                IDLE: begin
                    sd_cs   <= 1'b1;
                    sd_mosi <= 1'b1;
                    bit_cnt <= '0;
                    if (wr_start_en && sd_init_done && !wr_busy) begin
                        state    <= CMD;
                        wr_busy  <= 1'b1;
                        err_flag <= 1'b0;
                        sd_cs    <= 1'b0;
                        sd_mosi  <= cmd_frame[47];
                        tx_sr    <= {cmd_frame[46:0], 1'b1};
                    end
                end
                CMD: begin
                    if (bit_cnt == 6'd47) begin
                        state     <= WAIT_R1;
                        sd_mosi   <= 1'b1;
                        bit_cnt   <= '0;
                        wait_cnt  <= '0;
                        got_start <= 1'b0;
                    end else begin
                        sd_mosi <= tx_sr[47];
                        tx_sr   <= {tx_sr[46:0], 1'b1};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                WAIT_R1: begin
                    if (!got_start) begin
                        if (!sd_miso) begin
                            got_start <= 1'b1;
                            rx_sr     <= '0;
                            bit_cnt   <= 6'd1;
                        end else if (wait_cnt == {8'd0, TIMEOUT} - 24'd1) begin
                            state    <= TAIL;
                            err_flag <= 1'b1;
                            sd_cs    <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 24'd1;
                        end
                    end else begin
                        rx_sr <= {rx_sr[5:0], sd_miso};
                        if (bit_cnt == 6'd7) begin
                            bit_cnt   <= '0;
                            got_start <= 1'b0;
                            if ({rx_sr, sd_miso} == 8'h00) begin
                                state <= GAP;
                            end else begin
                                state    <= TAIL;
                                err_flag <= 1'b1;
                                sd_cs    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                GAP: begin
                    if (bit_cnt == 6'd7) begin
                        state   <= TOKEN;
                        bit_cnt <= '0;
                        wr_req  <= 1'b1;
                        sd_mosi <= 1'b1;
                        tx_sr   <= {7'b1111110, {41{1'b1}}};
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                TOKEN: begin
                    if (bit_cnt == 6'd7) begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        wr_req   <= 1'b1;
                        sd_mosi  <= wr_data[15];
                        tx_sr    <= {wr_data[14:0], {33{1'b1}}};
                    end else begin
                        sd_mosi <= tx_sr[47];
                        tx_sr   <= {tx_sr[46:0], 1'b1};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt == 6'd15) begin
                        bit_cnt <= '0;
                        if (word_cnt == 8'd255) begin
                            state    <= CRC;
                            word_cnt <= '0;
                            sd_mosi  <= 1'b1;
                        end else begin
                            // The request issued here is for the word after the one being loaded.
                            word_cnt <= word_cnt + 8'd1;
                            wr_req   <= (word_cnt != 8'd254);
                            sd_mosi  <= wr_data[15];
                            tx_sr    <= {wr_data[14:0], {33{1'b1}}};
                        end
                    end else begin
                        sd_mosi <= tx_sr[47];
                        tx_sr   <= {tx_sr[46:0], 1'b1};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                CRC: begin
                    if (bit_cnt == 6'd15) begin
                        state     <= WAIT_RESP;
                        bit_cnt   <= '0;
                        wait_cnt  <= '0;
                        got_start <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                WAIT_RESP: begin
                    if (!got_start) begin
                        if (!sd_miso) begin
                            got_start <= 1'b1;
                            rx_sr     <= '0;
                            bit_cnt   <= 6'd1;
                        end else if (wait_cnt == {8'd0, TIMEOUT} - 24'd1) begin
                            state    <= TAIL;
                            err_flag <= 1'b1;
                            sd_cs    <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 24'd1;
                        end
                    end else begin
                        rx_sr <= {rx_sr[5:0], sd_miso};
                        if (bit_cnt == 6'd4) begin
                            state     <= BUSY;
                            bit_cnt   <= '0;
                            got_start <= 1'b0;
                            wait_cnt  <= '0;
                            if (rx_sr[2:0] != 3'b010) begin
                                err_flag <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                BUSY: begin
                    if (sd_miso) begin
                        state   <= TAIL;
                        sd_cs   <= 1'b1;
                        bit_cnt <= '0;
                    end else if (wait_cnt == BUSY_TIMEOUT - 24'd1) begin
                        state    <= TAIL;
                        err_flag <= 1'b1;
                        sd_cs    <= 1'b1;
                        bit_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 24'd1;
                    end
                end
                TAIL: begin
                    sd_cs   <= 1'b1;
                    sd_mosi <= 1'b1;
                    if (bit_cnt == 6'd7) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else begin
                        // Busy drops and the error pulses together in the final tail cycle.
                        if (bit_cnt == 6'd6) begin
                            wr_busy <= 1'b0;
                            wr_err  <= err_flag;
                        end
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_block_wr.sv
// Bench for sd_spi_block_wr: a timeline model built from frame segments drives the card MISO and
// predicts {cs, mosi, req, busy, err} for every cycle; literal checks pin the captured frame contents.
module tb_sd_spi_block_wr;

    localparam int TMO = 1000;
    localparam int N   = 5000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_init_done = 1'b0;
    logic        wr_start_en = 1'b0;
    logic [31:0] wr_sec_addr = '0;
    logic [15:0] wr_data = '0;
    logic        sd_miso = 1'b1;
    logic        wr_req, wr_busy, wr_err, sd_cs, sd_mosi;
    logic [3:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int model_len = 0;
    bit active = 1'b0;

    logic [4:0]  exp_out [N];
    logic        drv_miso [N];
    int          req_cnt, err_cnt, err_idx, cs_rise_idx;
    logic        prev_cs;
    logic        cap_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  cmd_lit [6];

    sd_spi_block_wr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sd_init_done (sd_init_done),
        .wr_start_en  (wr_start_en),
        .wr_sec_addr  (wr_sec_addr),
        .wr_data      (wr_data),
        .wr_req       (wr_req),
        .wr_busy      (wr_busy),
        .wr_err       (wr_err),
        .sd_miso      (sd_miso),
        .sd_cs        (sd_cs),
        .sd_mosi      (sd_mosi),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: expected outputs per cycle offset from the start pulse, plus the card's MISO schedule
    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            exp_out[k]  = 5'b11000;
            drv_miso[k] = 1'b1;
        end
    endtask

    task automatic put(input int n, input logic cs, input logic mosi, input logic busy);
        exp_out[n] = {cs, mosi, 1'b0, busy, 1'b0};
    endtask

    task automatic build_idle(input int len);
        clear_model();
        model_len = len;
    endtask

    task automatic build_frame(input logic [31:0] addr, input int r, input logic [7:0] r1,
                               input int p, input logic [4:0] resp, input int b, input bit stuck);
        logic [47:0] cmd;
        logic [7:0]  tok;
        logic [15:0] word;
        bit          err;
        int          n;
        clear_model();
        cmd = {8'h58, addr, 8'hFF};
        tok = 8'hFE;
        err = 1'b0;
        n   = 1;
        for (int i = 47; i >= 0; i--) begin put(n, 1'b0, cmd[i], 1'b1); n++; end
        if (stuck) begin
            for (int i = 0; i < TMO; i++) begin put(n, 1'b0, 1'b1, 1'b1); n++; end
            err = 1'b1;
        end else begin
            for (int i = 0; i < r; i++) begin put(n, 1'b0, 1'b1, 1'b1); n++; end
            for (int i = 7; i >= 0; i--) begin
                put(n, 1'b0, 1'b1, 1'b1);
                drv_miso[n] = r1[i];
                n++;
            end
            if (r1 != 8'h00) begin
                err = 1'b1;
            end else begin
                for (int i = 0; i < 8; i++) begin put(n, 1'b0, 1'b1, 1'b1); n++; end
                for (int i = 7; i >= 0; i--) begin
                    put(n, 1'b0, tok[i], 1'b1);
                    if (i == 7) exp_out[n][2] = 1'b1;
                    n++;
                end
                for (int w = 0; w < 256; w++) begin
                    word = 16'(w);
                    for (int i = 15; i >= 0; i--) begin
                        put(n, 1'b0, word[i], 1'b1);
                        if (i == 15 && w < 255) exp_out[n][2] = 1'b1;
                        n++;
                    end
                end
                for (int i = 0; i < 16 + p; i++) begin put(n, 1'b0, 1'b1, 1'b1); n++; end
                for (int i = 4; i >= 0; i--) begin
                    put(n, 1'b0, 1'b1, 1'b1);
                    drv_miso[n] = resp[i];
                    n++;
                end
                if (resp[3:1] != 3'b010) err = 1'b1;
                for (int i = 0; i < b; i++) begin
                    put(n, 1'b0, 1'b1, 1'b1);
                    drv_miso[n] = 1'b0;
                    n++;
                end
                put(n, 1'b0, 1'b1, 1'b1);
                n++;
            end
        end
        for (int i = 0; i < 7; i++) begin put(n, 1'b1, 1'b1, 1'b1); n++; end
        exp_out[n] = {1'b1, 1'b1, 1'b0, 1'b0, err};
        n++;
        model_len = n + 10;
    endtask

    function automatic logic [15:0] get_bits(input int start, input int width);
        logic [15:0] v;
        v = '0;
        for (int j = 0; j < width; j++) begin
            v = {v[14:0], (start + j < cap_q.size()) ? cap_q[start + j] : 1'bx};
        end
        return v;
    endfunction

    // Compare process, card MISO driver, MOSI capture and incrementing-word source
    initial forever begin
        @(negedge clk);
        if (active) begin
            int i;
            i = cyc - base;
            if (i < model_len) begin
                check($sformatf("cycle%0d", i), {27'd0, sd_cs, sd_mosi, wr_req, wr_busy, wr_err},
                      {27'd0, exp_out[i]});
            end
            if (sd_cs === 1'b0) cap_q.push_back(sd_mosi);
            if (wr_err === 1'b1) begin err_cnt++; err_idx = i; end
            if (prev_cs === 1'b0 && sd_cs === 1'b1 && cs_rise_idx < 0) cs_rise_idx = i;
            if (wr_req === 1'b1) begin
                req_cnt++;
                wr_data = 16'(req_cnt - 1);
            end
            sd_miso = (i < model_len) ? drv_miso[i] : 1'b1;
            prev_cs = sd_cs;
        end else begin
            sd_miso = 1'b1;
        end
    end

    // Driver: pulse start, optionally pulse a second start at mid_k, optionally stop once stop_req words requested
    task automatic run_write(input logic [31:0] addr, input int mid_k, input int stop_req);
        bit stopped;
        stopped     = 1'b0;
        req_cnt     = 0;
        err_cnt     = 0;
        err_idx     = -1;
        cs_rise_idx = -1;
        prev_cs     = 1'b1;
        cap_q.delete();
        @(posedge clk); #2;
        base        = cyc;
        wr_sec_addr = addr;
        wr_start_en = 1'b1;
        active      = 1'b1;
        for (int k = 1; k < model_len; k++) begin
            @(posedge clk); #2;
            wr_start_en = (k == mid_k);
            if (k == mid_k) wr_sec_addr = 32'h0000_1234;
            if (stop_req > 0 && req_cnt >= stop_req) begin
                stopped = 1'b1;
                break;
            end
        end
        wr_start_en = 1'b0;
        if (stopped) begin
            active = 1'b0;
        end else begin
            @(negedge clk); #1;
            active = 1'b0;
        end
    endtask

    initial begin
        cmd_lit = '{8'h58, 8'h00, 8'h00, 8'h4E, 8'h20, 8'hFF};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cs", sd_cs, 1);
        check("rst_mosi", sd_mosi, 1);
        check("rst_busy", wr_busy, 0);
        check("rst_req", wr_req, 0);
        check("rst_err", wr_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start before init is ignored
        build_idle(30);
        run_write(32'h0000_0055, -1, 0);
        check("preinit_busy", wr_busy, 0);
        check("preinit_req", req_cnt, 0);
        sd_init_done = 1'b1;
        repeat (2) @(posedge clk);

        // Normal write to sector 20000 with a stray start mid-DATA
        build_frame(32'd20000, 16, 8'h00, 4, 5'b00101, 100, 1'b0);
        run_write(32'd20000, 1000, 0);
        check("norm_req_count", req_cnt, 256);
        check("norm_err_count", err_cnt, 0);
        for (int k = 0; k < 6; k++) check($sformatf("norm_cmd_byte%0d", k), get_bits(8 * k, 8), cmd_lit[k]);
        check("norm_token", get_bits(80, 8), 8'hFE);
        check("norm_word0", get_bits(88, 16), 16'h0000);
        check("norm_word255", get_bits(88 + 16 * 255, 16), 16'h00FF);
        check("norm_crc", get_bits(88 + 4096, 16), 16'hFFFF);
        exp_q.delete();
        for (int w = 0; w < 256; w++) exp_q.push_back(16'(w));
        for (int w = 0; w < 256; w++) check($sformatf("norm_block_word%0d", w), get_bits(88 + 16 * w, 16), exp_q.pop_front());

        // R1 error
        build_frame(32'h0000_0100, 16, 8'h04, 0, 5'b00000, 0, 1'b0);
        run_write(32'h0000_0100, -1, 0);
        check("r1err_req_count", req_cnt, 0);
        check("r1err_err_count", err_cnt, 1);
        check("r1err_cs_rise", cs_rise_idx, 73);
        check("r1err_err_cycle", err_idx, 80);

        // Data rejected (response 0x0B)
        build_frame(32'h0000_0200, 16, 8'h00, 2, 5'b01011, 20, 1'b0);
        run_write(32'h0000_0200, -1, 0);
        check("rej_req_count", req_cnt, 256);
        check("rej_err_count", err_cnt, 1);
        check("rej_err_cycle", err_idx, 4236);

        // No R1 at all
        build_frame(32'h0000_0300, 0, 8'h00, 0, 5'b00000, 0, 1'b1);
        run_write(32'h0000_0300, -1, 0);
        check("tmo_req_count", req_cnt, 0);
        check("tmo_err_count", err_cnt, 1);
        check("tmo_cs_rise", cs_rise_idx, 1049);
        check("tmo_err_cycle", err_idx, 1056);

        // Reset at word 100, then a clean write
        build_frame(32'h0000_0400, 16, 8'h00, 4, 5'b00101, 10, 1'b0);
        run_write(32'h0000_0400, -1, 101);
        check("mid_reset_point", req_cnt, 101);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs", sd_cs, 1);
        check("mid_rst_mosi", sd_mosi, 1);
        check("mid_rst_busy", wr_busy, 0);
        check("mid_rst_req", wr_req, 0);
        check("mid_rst_err", wr_err, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_hold_err", wr_err, 0);
            check("mid_rst_hold_cs", sd_cs, 1);
        end
        rst_n = 1'b1;
        build_frame(32'h0000_0500, 3, 8'h00, 0, 5'b00101, 5, 1'b0);
        run_write(32'h0000_0500, -1, 0);
        check("after_rst_req_count", req_cnt, 256);
        check("after_rst_err_count", err_cnt, 0);
        check("after_rst_word255", get_bits(75 + 16 * 255, 16), 16'h00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
